segment_display_monitor: RTL

Passive receiver for the 8-digit multiplexed seven-segment interface. It samples the active-low anode and cathode lines driven onto the board and decodes each settled digit pattern back into a hex nibble. Once all eight digits have been captured, it presents the reassembled 32-bit word. It sits on the board-side pins, or in the system testbench, as the readback and self-check path for the display output.

---
 rtl/segment_display_monitor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/segment_display_monitor.sv
// segment_display_monitor
// Passive readback of an 8-digit multiplexed seven-segment display.
// Synchronizes the active-low anode/cathode pins, waits for each pattern to
// settle, decodes the lit digit back to a hex nibble and reassembles the
// 32-bit word once all eight digits have been seen.
//
// state  | meaning
// SETTLE | counting consecutive identical samples of the pin vector
// HOLD   | current pattern already accepted, waiting for the pins to change

module segment_display_monitor #(
  parameter int C_SETTLE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  AN,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  output logic [31:0] DATA,
  output logic        DATA_VALID,
  output logic [7:0]  DIGIT_MASK,
  output logic        ERROR
);

  localparam int CW = $clog2(C_SETTLE_CYCLES + 1);
  // Last count before acceptance: the increment out of this value is the
  // C_SETTLE_CYCLES-th identical sample.
  localparam logic [CW-1:0] CNT_LAST = CW'(C_SETTLE_CYCLES - 2);

  typedef enum logic {ST_SETTLE, ST_HOLD} state_t;

  logic [15:0]   pins;
  logic [15:0]   sync1_q;
  logic [15:0]   v_q;
  logic [15:0]   v_prev_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   shadow_q;
  logic [31:0]   shadow_d;
  logic [7:0]    mask_q;
  logic [7:0]    mask_d;
  logic [31:0]   data_q;
  logic          valid_q;
  logic          err_q;

  logic          v_changed;
  logic [7:0]    en;
  logic [6:0]    seg;
  logic          en_onehot;
  logic          seg_ok;
  logic [3:0]    seg_nib;
  logic          accept_now;

  assign pins = {AN, CA, CB, CC, CD, CE, CF, CG, DP};

  // Two-flop synchronizer; idle value is all-ones (nothing enabled, all dark).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '1;
      v_q     <= '1;
    end else begin
      sync1_q <= pins;
      v_q     <= sync1_q;
    end
  end

  assign v_changed  = (v_q != v_prev_q);
  assign en         = ~v_q[15:8];
  assign seg        = v_q[7:1];
  assign en_onehot  = (en != 8'h00) && ((en & (en - 8'd1)) == 8'h00);
  assign accept_now = (state_q == ST_SETTLE) && !v_changed && (cnt_q == CNT_LAST);

  // Segment pattern {CA..CG}, active-low, back to a hex nibble.
  always_comb begin
    seg_ok  = 1'b1;
    seg_nib = 4'h0;
    case (seg)
      7'b0000001: seg_nib = 4'h0;
      7'b1001111: seg_nib = 4'h1;
      7'b0010010: seg_nib = 4'h2;
      7'b0000110: seg_nib = 4'h3;
      7'b1001100: seg_nib = 4'h4;
      7'b0100100: seg_nib = 4'h5;
      7'b0100000: seg_nib = 4'h6;
      7'b0001111: seg_nib = 4'h7;
      7'b0000000: seg_nib = 4'h8;
      7'b0001100: seg_nib = 4'h9;
      7'b0001000: seg_nib = 4'hA;
      7'b1100000: seg_nib = 4'hB;
      7'b1110010: seg_nib = 4'hC;
      7'b1000010: seg_nib = 4'hD;
      7'b0110000: seg_nib = 4'hE;
      7'b0111000: seg_nib = 4'hF;
      default:    seg_ok  = 1'b0;
    endcase
  end

  // Candidate shadow/mask if the current pattern is captured; only meaningful
  // when exactly one digit is enabled.
  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q | en;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        shadow_d[4*i +: 4] = seg_nib;
      end
    end
  end

  // Stability FSM plus accept/capture and registered output pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= '0;
      v_prev_q <= '1;
      shadow_q <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      v_prev_q <= v_q;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        ST_SETTLE: begin
          if (v_changed) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (v_changed) begin
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_SETTLE;
        end
      endcase

      // Blank anodes are the normal gap between digits and are ignored.
      if (accept_now && (en != 8'h00)) begin
        if (!en_onehot || !seg_ok) begin
          err_q <= 1'b1;
        end else begin
          shadow_q <= shadow_d;
          if (mask_d == 8'hFF) begin
            data_q  <= shadow_d;
            valid_q <= 1'b1;
            mask_q  <= 8'h00;
          end else begin
            mask_q <= mask_d;
          end
        end
      end
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = valid_q;
  assign DIGIT_MASK = mask_q;
  assign ERROR      = err_q;

endmodule
